tt_readout_sched: RTL and testbench

- Schedules readout of four 32-bit time-tag sources onto one shared 32-bit output stream.
- Source data is selected through the existing 4:1 32-bit selector.
- Two modes:
  - round-robin: service whichever sources present data, fairly.
  - frame: collect exactly one word from each source in fixed order 0,1,2,3 and mark the last word.
- Sits between the per-source time-tag capture registers and the readout FIFO/AXI-side buffer.

---
 rtl/tt_readout_pkg.sv | 24 ++
 rtl/mux_4.sv | 28 ++
 rtl/tt_readout_sched.sv | 150 +++++++++++++++
 tb/tb_tt_readout_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_readout_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tt_readout_pkg: shared encodings for the time-tag readout scheduler |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package tt_readout_pkg;

  localparam int N_SRC = 4;
  localparam int SEL_W = 2;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FRAME = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RR   = 3'd1,
    ST_SEQ0 = 3'd2,
    ST_SEQ1 = 3'd3,
    ST_SEQ2 = 3'd4,
    ST_SEQ3 = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mux_4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_4: 4:1 word selector                                            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mux_4 #(
  parameter int W = 32
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  output logic [W-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tt_readout_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tt_readout_sched: round-robin / framed readout of four time-tag     |
// | sources onto one registered output stream. Rev 1.0                  |
// +--------------------------------------------------------------------+
module tt_readout_sched #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] src_data0,
  input  logic [DATA_W-1:0] src_data1,
  input  logic [DATA_W-1:0] src_data2,
  input  logic [DATA_W-1:0] src_data3,
  input  logic [N_SRC-1:0]  src_valid,
  output logic [N_SRC-1:0]  src_ready,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  import tt_readout_pkg::*;

  state_e            state_q, state_d, seq_next;
  logic [SEL_W-1:0]  ptr_q, ptr_d, sel_q, sel_d;
  logic [SEL_W-1:0]  gnt_idx, rr_idx, seq_k;
  logic              gnt_v, rr_found, seq_act, load_ok, last_w;
  logic [DATA_W-1:0] mux_out, out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;
  logic              out_last_q, out_last_d, out_valid_q, out_valid_d;

  assign load_ok = !out_valid_q || out_ready;

  mux_4 #(.W(DATA_W)) u_mux (
    .sel (sel_d),
    .in0 (src_data0),
    .in1 (src_data1),
    .in2 (src_data2),
    .in3 (src_data3),
    .out (mux_out)
  );

  // Search starts just after the last granted source so every requester gets a turn.
  always_comb begin : rr_search
    logic [SEL_W-1:0] cand;
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = ptr_q + SEL_W'(i);
      if (!rr_found && src_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin : fsm
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_v    = 1'b0;
    gnt_idx  = ptr_q;
    last_w   = 1'b0;
    seq_act  = 1'b0;
    seq_k    = '0;
    seq_next = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_FRAME)  state_d = ST_SEQ0;
        else if (|src_valid)     state_d = ST_RR;
      end
      ST_RR: begin
        if (rr_found) begin
          if (load_ok) begin
            gnt_v   = 1'b1;
            gnt_idx = rr_idx;
            ptr_d   = rr_idx;
          end
        end else if (!out_valid_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEQ0: begin seq_act = 1'b1; seq_k = 2'd0; seq_next = ST_SEQ1; end
      ST_SEQ1: begin seq_act = 1'b1; seq_k = 2'd1; seq_next = ST_SEQ2; end
      ST_SEQ2: begin seq_act = 1'b1; seq_k = 2'd2; seq_next = ST_SEQ3; end
      ST_SEQ3: begin seq_act = 1'b1; seq_k = 2'd3; seq_next = ST_IDLE; end
      default: state_d = ST_IDLE;
    endcase
    if (seq_act && src_valid[seq_k] && load_ok) begin
      gnt_v   = 1'b1;
      gnt_idx = seq_k;
      last_w  = (seq_k == 2'd3);
      state_d = seq_next;
    end
    // A reset cycle must never hand out an accept pulse.
    if (rst) gnt_v = 1'b0;
  end

  always_comb begin : out_stage
    src_ready = '0;
    if (gnt_v) src_ready[gnt_idx] = 1'b1;
    sel_d       = gnt_v ? gnt_idx : sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    if (load_ok) begin
      out_valid_d = gnt_v;
      if (gnt_v) begin
        out_data_d = mux_out;
        out_src_d  = gnt_idx;
        out_last_d = last_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd3;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
    end
  end

  assign sel       = sel_d;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tt_readout_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tt_readout_sched: vector table, directed corner sequences and    |
// | randomized traffic against a transaction-level model. Rev 1.0       |
// +--------------------------------------------------------------------+
module tb_tt_readout_sched;

  logic        clk = 1'b0;
  logic        rst, mode, out_ready;
  logic [31:0] d0, d1, d2, d3;
  logic [3:0]  src_valid, src_ready;
  logic [1:0]  sel, out_src;
  logic [31:0] out_data;
  logic        out_last, out_valid, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tt_readout_sched #(.DATA_W(32), .N_SRC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .src_data0 (d0),
    .src_data1 (d1),
    .src_data2 (d2),
    .src_data3 (d3),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // Model: active flag, frame position (-1 = round-robin), fairness pointer, one-word output slot.
  int          m_known = 0;
  int          m_act, m_frame, m_ptr, m_sel, m_ov, m_os, m_ol;
  logic [31:0] m_od;
  logic [3:0]  pre_rdy;
  logic [1:0]  pre_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input int s);
    case (s)
      0:       return d0;
      1:       return d1;
      2:       return d2;
      default: return d3;
    endcase
  endfunction

  function automatic int model_grant();
    if (rst || m_act == 0) return -1;
    if (m_ov != 0 && !out_ready) return -1;
    if (m_frame < 0) begin
      for (int k = 1; k <= 4; k++)
        if (src_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
    end
    return src_valid[m_frame] ? m_frame : -1;
  endfunction

  task automatic model_update(input int g);
    int old_ov;
    if (rst) begin
      m_act = 0; m_frame = -1; m_ptr = 3; m_sel = 0;
      m_ov = 0; m_od = 0; m_os = 0; m_ol = 0; m_known = 1;
      return;
    end
    old_ov = m_ov;
    if (m_ov == 0 || out_ready) begin
      if (g >= 0) begin
        m_ov = 1; m_od = word(g); m_os = g; m_ol = (m_frame == 3) ? 1 : 0;
      end else begin
        m_ov = 0;
      end
    end
    if (g >= 0) m_sel = g;
    if (m_act == 0) begin
      if (mode) begin m_act = 1; m_frame = 0; end
      else if (src_valid != 4'b0) begin m_act = 1; m_frame = -1; end
    end else if (m_frame < 0) begin
      if (g >= 0) m_ptr = g;
      else if (src_valid == 4'b0 && old_ov == 0) m_act = 0;
    end else if (g >= 0) begin
      if (m_frame == 3) begin m_act = 0; m_frame = -1; end
      else m_frame++;
    end
  endtask

  // Inputs are set just after a rising edge; one call covers one clock.
  task automatic step();
    int         g;
    logic [3:0] e_rdy;
    #2;
    pre_rdy = src_ready;
    pre_sel = sel;
    g = model_grant();
    if (m_known != 0) begin
      e_rdy = 4'b0;
      if (g >= 0) e_rdy[g[1:0]] = 1'b1;
      chk("src_ready", 32'(src_ready), 32'(e_rdy));
      chk("sel", 32'(sel), (g >= 0) ? 32'(g) : 32'(m_sel));
    end
    @(posedge clk);
    model_update(g);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_act));
    if (m_ov != 0) begin
      chk("out_data", out_data, m_od);
      chk("out_src", 32'(out_src), 32'(m_os));
      chk("out_last", 32'(out_last), 32'(m_ol));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = 4'b0; mode = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [3:0] valid;
    logic [3:0] e_rdy;
    logic [1:0] e_sel;
    logic       e_ov;
    logic [1:0] e_src;
    logic       e_busy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int gl [$];
    int ll [$];
    int busy_after;
    logic [3:0] want;

    d0 = 32'hA000_0000; d1 = 32'hA000_0001; d2 = 32'hA000_0002; d3 = 32'hA000_0003;
    do_reset();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_src", 32'(out_src), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst sel", 32'(sel), 32'd0);
    chk("rst src_ready", 32'(src_ready), 32'd0);

    // Round-robin fairness with all four sources requesting, then drain to idle.
    tbl[0] = '{4'hF, 4'h0, 2'd0, 1'b0, 2'd0, 1'b1};
    tbl[1] = '{4'hF, 4'h1, 2'd0, 1'b1, 2'd0, 1'b1};
    tbl[2] = '{4'hF, 4'h2, 2'd1, 1'b1, 2'd1, 1'b1};
    tbl[3] = '{4'hF, 4'h4, 2'd2, 1'b1, 2'd2, 1'b1};
    tbl[4] = '{4'hF, 4'h8, 2'd3, 1'b1, 2'd3, 1'b1};
    tbl[5] = '{4'hF, 4'h1, 2'd0, 1'b1, 2'd0, 1'b1};
    tbl[6] = '{4'hF, 4'h2, 2'd1, 1'b1, 2'd1, 1'b1};
    tbl[7] = '{4'h0, 4'h0, 2'd1, 1'b0, 2'd1, 1'b1};
    tbl[8] = '{4'h0, 4'h0, 2'd1, 1'b0, 2'd1, 1'b0};
    mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      src_valid = tbl[i].valid;
      step();
      chk("tbl src_ready", 32'(pre_rdy), 32'(tbl[i].e_rdy));
      chk("tbl sel", 32'(pre_sel), 32'(tbl[i].e_sel));
      chk("tbl out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
      chk("tbl out_src", 32'(out_src), 32'(tbl[i].e_src));
      chk("tbl busy", 32'(busy), 32'(tbl[i].e_busy));
      if (tbl[i].e_ov) begin
        chk("tbl out_data", out_data, 32'hA000_0000 + 32'(tbl[i].e_src));
        chk("tbl out_last", 32'(out_last), 32'd0);
      end
    end

    // Back-pressure: the first word holds while out_ready is low.
    do_reset();
    src_valid = 4'b0101;
    step(); step();
    chk("bp first data", out_data, 32'hA000_0000);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp src_ready", 32'(pre_rdy), 32'd0);
      chk("bp hold data", out_data, 32'hA000_0000);
      chk("bp hold valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp release grant", 32'(pre_rdy), 32'h4);
    chk("bp release src", 32'(out_src), 32'd2);
    step();
    chk("bp next src", 32'(out_src), 32'd0);
    src_valid = 4'b0;
    step(); step(); step();

    // Frame order with requests arriving out of order.
    do_reset();
    mode = 1'b1; want = 4'b0; busy_after = -1;
    for (int cyc = 0; cyc < 24 && gl.size() < 4; cyc++) begin
      if (cyc == 0) want[3] = 1'b1;
      if (cyc == 3) want[1] = 1'b1;
      if (cyc == 6) want[0] = 1'b1;
      if (cyc == 9) want[2] = 1'b1;
      src_valid = want;
      step();
      want = want & ~pre_rdy;
      if (pre_rdy == 4'h8) busy_after = busy;
      if (out_valid && pre_rdy != 4'b0) begin
        gl.push_back(out_src);
        ll.push_back(out_last);
      end
    end
    mode = 1'b0; src_valid = 4'b0;
    chk("frame words", 32'(gl.size()), 32'd4);
    for (int i = 0; i < gl.size(); i++) begin
      chk("frame order", 32'(gl[i]), 32'(i));
      chk("frame last", 32'(ll[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("frame busy drop", 32'(busy_after), 32'd0);
    step(); step();

    // Mode dropped to round-robin while the frame sits at source 2.
    do_reset();
    mode = 1'b1; src_valid = 4'hF; gl.delete(); ll.delete(); busy_after = -1;
    for (int cyc = 0; cyc < 20 && gl.size() < 6; cyc++) begin
      step();
      if (pre_rdy != 4'b0) begin
        gl.push_back(oh2i(pre_rdy));
        ll.push_back(out_last);
        if (gl.size() == 2) mode = 1'b0;
        if (gl.size() == 4) busy_after = busy;
      end
    end
    chk("midmode grants", 32'(gl.size()), 32'd6);
    for (int i = 0; i < gl.size(); i++) begin
      chk("midmode order", 32'(gl[i]), 32'(i % 4));
      chk("midmode last", 32'(ll[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("midmode busy", 32'(busy_after), 32'd0);

    // Reset with a word pending and the frame at source 1.
    do_reset();
    mode = 1'b1; src_valid = 4'b0001; out_ready = 1'b0;
    step(); step();
    chk("midrst pending", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst valid", 32'(out_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst ready", 32'(pre_rdy), 32'd0);
    rst = 1'b0; mode = 1'b0; src_valid = 4'hF; out_ready = 1'b1;
    step(); step();
    chk("midrst first grant", 32'(pre_rdy), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mode      = ($urandom_range(0, 3) == 0);
      src_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
